sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 137 +++++++++++++
 tb/tb_sdram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-master SDRAM command arbiter: video burst reads against single-word CPU accesses,
// with bounded CPU starvation and one outstanding transaction at a time.
module sdram_arbiter #(
  parameter int C_addr_bits   = 22,
  parameter int C_data_bits   = 32,
  parameter int C_burst       = 8,
  parameter int C_cpu_maxwait = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [C_addr_bits-1:0]   cpu_addr,
  input  logic [C_data_bits-1:0]   cpu_wdata,
  input  logic [C_data_bits/8-1:0] cpu_be,
  output logic                     cpu_ack,
  output logic                     cpu_rvalid,
  output logic [C_data_bits-1:0]   cpu_rdata,
  input  logic                     vid_req,
  input  logic [C_addr_bits-1:0]   vid_addr,
  output logic                     vid_ack,
  output logic                     vid_rvalid,
  output logic [C_data_bits-1:0]   vid_rdata,
  output logic                     mem_valid,
  output logic                     mem_we,
  output logic [C_addr_bits-1:0]   mem_addr,
  output logic [C_data_bits-1:0]   mem_wdata,
  output logic [C_data_bits/8-1:0] mem_be,
  output logic [4:0]               mem_len,
  input  logic                     mem_ready,
  input  logic                     mem_rvalid,
  input  logic [C_data_bits-1:0]   mem_rdata,
  output logic                     busy,
  output logic                     proto_err,
  output logic [1:0]               dbg_state,
  output logic [7:0]               dbg_wait_cnt
);

  // Handshake: a command transfers on the cycle mem_valid && mem_ready; requesters hold
  // req and fields until their one-cycle ack; read data is one word per mem_rvalid.
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RDATA = 2'd2} state_t;

  state_t                   state, state_nxt;
  logic                     owner_vid;
  logic                     lat_we;
  logic [C_addr_bits-1:0]   lat_addr;
  logic [C_data_bits-1:0]   lat_wdata;
  logic [C_data_bits/8-1:0] lat_be;
  logic [4:0]               lat_len;
  logic [4:0]               cnt;
  logic [7:0]               wait_cnt;
  logic                     cpu_pend, vid_pend;
  logic                     grant_vid, grant_cpu, accept, last_word;

  // Video wins ties until the CPU has been passed over C_cpu_maxwait times.
  assign grant_vid = (state == IDLE) && vid_req &&
                     !(cpu_req && (wait_cnt == 8'(C_cpu_maxwait)));
  assign grant_cpu = (state == IDLE) && cpu_req && !grant_vid;
  assign accept    = (state == ISSUE) && mem_ready;
  assign last_word = (state == RDATA) && mem_rvalid && (cnt == 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vid || grant_cpu) state_nxt = ISSUE;
      ISSUE:   if (mem_ready) state_nxt = lat_we ? IDLE : RDATA;
      RDATA:   if (last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_vid <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_len   <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
      cpu_pend  <= 1'b0;
      vid_pend  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (grant_vid) begin
        owner_vid <= 1'b1;
        lat_we    <= 1'b0;
        lat_addr  <= vid_addr;
        lat_wdata <= '0;
        lat_be    <= '1;
        lat_len   <= 5'(C_burst);
        if (cpu_req && (wait_cnt != 8'(C_cpu_maxwait))) wait_cnt <= wait_cnt + 8'd1;
      end else if (grant_cpu) begin
        owner_vid <= 1'b0;
        lat_we    <= cpu_we;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        lat_be    <= cpu_be;
        lat_len   <= 5'd1;
        wait_cnt  <= '0;
      end
      if (accept && !lat_we) cnt <= lat_len;
      else if ((state == RDATA) && mem_rvalid && (cnt != 5'd0)) cnt <= cnt - 5'd1;
      // A pending request is one seen high and not yet acknowledged.
      cpu_pend <= cpu_req && !cpu_ack;
      vid_pend <= vid_req && !vid_ack;
      if ((mem_rvalid && (state != RDATA)) || (cpu_pend && !cpu_req) || (vid_pend && !vid_req))
        proto_err <= 1'b1;
    end
  end

  always_comb begin
    mem_valid  = (state == ISSUE);
    mem_we     = mem_valid && lat_we;
    mem_addr   = mem_valid ? lat_addr  : '0;
    mem_wdata  = mem_valid ? lat_wdata : '0;
    mem_be     = mem_valid ? lat_be    : '0;
    mem_len    = mem_valid ? lat_len   : '0;
    cpu_ack    = accept && !owner_vid;
    vid_ack    = accept && owner_vid;
    cpu_rvalid = (state == RDATA) && mem_rvalid && !owner_vid;
    vid_rvalid = (state == RDATA) && mem_rvalid && owner_vid;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    vid_rdata  = vid_rvalid ? mem_rdata : '0;
    busy       = (state != IDLE);
  end

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: read data checked through an expected-value queue,
// grant order checked against a small wait-counter model.
module tb_sdram_arbiter;
  localparam int AW = 22;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [3:0]    cpu_be;
  logic          cpu_ack, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic          vid_ack, vid_rvalid;
  logic [DW-1:0] vid_rdata;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic [4:0]    mem_len;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy, proto_err;
  logic [1:0]    dbg_state;
  logic [7:0]    dbg_wait_cnt;

  logic [DW-1:0] exp_q[$];
  logic          order_q[$];
  logic [7:0]    last_wait;
  logic [7:0]    model_wait;
  logic          exp_vid;
  int            n_cmp = 0;
  int            n_err = 0;

  sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rvalid(vid_rvalid),
    .vid_rdata(vid_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_len(mem_len), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err),
    .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_valid"}, mem_valid, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_be"}, mem_be, 0);
    check({tag, "_mem_len"}, mem_len, 0);
    check({tag, "_acks"}, {cpu_ack, vid_ack}, 0);
    check({tag, "_rvalids"}, {cpu_rvalid, vid_rvalid}, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_vid_rdata"}, vid_rdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // Entered just after a negedge; returns 1 time unit after the negedge where mem_valid is seen.
  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    #1;
    while (!mem_valid && t < 40) begin
      if (dbg_state == 2'd0) last_wait = dbg_wait_cnt;
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_valid_timeout"}, mem_valid, 1);
  endtask

  // Entered and left at a negedge; drives n read words and checks the owner's return path.
  task automatic feed_words(input int n, input bit to_vid, input string tag);
    for (int i = 0; i < n; i++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
      exp_q.push_back(mem_rdata);
      #1;
      check({tag, "_rvalid"}, to_vid ? vid_rvalid : cpu_rvalid, 1);
      check({tag, "_other_rvalid"}, to_vid ? cpu_rvalid : vid_rvalid, 0);
      check({tag, "_rdata"}, to_vid ? vid_rdata : cpu_rdata, exp_q.pop_front());
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = '0;
    vid_req = 0; vid_addr = '0;
    mem_ready = 0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    last_wait = '0;
    @(negedge clk); @(negedge clk);
    #1;
    check_quiet("reset");
    check("reset_proto_err", proto_err, 0);
    check("reset_wait_cnt", dbg_wait_cnt, 0);

    // Video-only burst
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 22'h100; mem_ready = 1'b1;
    wait_valid("vid");
    check("vid_addr", mem_addr, 22'h100);
    check("vid_len", mem_len, 8);
    check("vid_we", mem_we, 0);
    check("vid_ack", vid_ack, 1);
    check("vid_no_cpu_ack", cpu_ack, 0);
    @(negedge clk);
    vid_req = 1'b0; mem_ready = 1'b0;
    #1;
    check("vid_rdata_state", dbg_state, 2);
    check("vid_ack_once", vid_ack, 0);
    @(negedge clk);
    feed_words(8, 1'b1, "vid");
    #1;
    check("vid_done_busy", busy, 0);
    check("vid_done_state", dbg_state, 0);
    check("vid_done_rvalid", vid_rvalid, 0);

    // CPU write with delayed mem_ready
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h20; cpu_wdata = 32'hDEADBEEF; cpu_be = 4'hF;
    wait_valid("wr");
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      check("wr_addr", mem_addr, 22'h20);
      check("wr_wdata", mem_wdata, 32'hDEADBEEF);
      check("wr_be", mem_be, 4'hF);
      check("wr_we", mem_we, 1);
      check("wr_len", mem_len, 1);
      check("wr_ack", cpu_ack, (i == 3) ? 1 : 0);
      if (i < 3) begin
        @(negedge clk);
        #1;
      end
    end
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; mem_ready = 1'b0;
    #1;
    check("wr_idle_state", dbg_state, 0);
    check("wr_no_rvalid", cpu_rvalid, 0);
    check("wr_ack_once", cpu_ack, 0);

    // CPU read of one word
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 22'h40; mem_ready = 1'b1;
    wait_valid("rd");
    check("rd_ack", cpu_ack, 1);
    check("rd_len", mem_len, 1);
    check("rd_we", mem_we, 0);
    @(negedge clk);
    cpu_req = 1'b0; mem_ready = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    exp_q.push_back(32'h12345678);
    #1;
    check("rd_rvalid", cpu_rvalid, 1);
    check("rd_vid_rvalid", vid_rvalid, 0);
    check("rd_rdata", cpu_rdata, exp_q.pop_front());
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("rd_rvalid_one_cycle", cpu_rvalid, 0);
    check("rd_done_busy", busy, 0);

    // Contention: both requesting continuously
    @(negedge clk);
    model_wait = '0;
    for (int r = 0; r < 2; r++) begin
      order_q.push_back(1'b1); order_q.push_back(1'b1);
      order_q.push_back(1'b1); order_q.push_back(1'b0);
    end
    vid_req = 1'b1; vid_addr = 22'h200;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'h30; cpu_wdata = 32'hA5A5_0000; cpu_be = 4'h3;
    mem_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_valid("cont");
      exp_vid = order_q.pop_front();
      check("cont_vid_ack", vid_ack, exp_vid);
      check("cont_cpu_ack", cpu_ack, !exp_vid);
      if (exp_vid) begin
        if (model_wait != 8'd3) model_wait = model_wait + 8'd1;
      end else begin
        check("cont_wait_before_cpu", last_wait, 3);
        model_wait = '0;
      end
      check("cont_wait_cnt", dbg_wait_cnt, model_wait);
      @(negedge clk);
      if (exp_vid) feed_words(8, 1'b1, "cont_vid");
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    wait_valid("tail");
    check("tail_vid_ack", vid_ack, 1);
    @(negedge clk);
    vid_req = 1'b0; mem_ready = 1'b0;
    feed_words(8, 1'b1, "tail_vid");
    #1;
    check("cont_proto_err", proto_err, 0);
    check("cont_done_busy", busy, 0);

    // Stray read data in IDLE
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("stray_no_cpu_rvalid", cpu_rvalid, 0);
    check("stray_no_vid_rvalid", vid_rvalid, 0);
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check("stray_proto_err", proto_err, 1);
    repeat (3) @(negedge clk);
    #1;
    check("stray_sticky", proto_err, 1);

    // Reset in the middle of a video burst
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 22'h300; mem_ready = 1'b1;
    wait_valid("abort");
    check("abort_ack", vid_ack, 1);
    @(negedge clk);
    vid_req = 1'b0; mem_ready = 1'b0;
    feed_words(3, 1'b1, "abort_vid");
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    check_quiet("abort_reset");
    check("abort_proto_err", proto_err, 0);
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("abort_no_vid_rvalid", vid_rvalid, 0);
      check("abort_no_ack", vid_ack, 0);
      check("abort_idle", busy, 0);
      @(negedge clk);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'h44; mem_ready = 1'b1;
    wait_valid("post");
    check("post_ack", cpu_ack, 1);
    @(negedge clk);
    cpu_req = 1'b0; mem_ready = 1'b0;
    feed_words(1, 1'b0, "post_cpu");
    #1;
    check("post_busy", busy, 0);
    check("post_proto_err", proto_err, 0);
    check("post_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
